// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared constants, types and FSM states for the PE-row
//                filter scratchpad receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package pe_pkg;

    localparam int FIL_DATA_W     = 16;
    localparam int FIL_SPAD_DEPTH = 224;

    typedef logic [FIL_DATA_W-1:0] fil_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } fil_rx_state_t;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/fil_spad_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fil_spad_mem
//  Description : 1W/1R synchronous scratchpad RAM with registered read.
//                A same-cycle read and write to one address returns the old word.
//  Revision    : 1.0  initial release
// ============================================================================
module fil_spad_mem #(
    parameter int W      = 16,
    parameter int DEPTH  = 224,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : fil_spad_mem
`default_nettype wire

// File: rtl/fil_spad_rx.sv
`default_nettype none
// ============================================================================
//  Module      : fil_spad_rx
//  Description : PE-row filter scratchpad receiver: captures the filter-bank
//                weight broadcast into a local spad and serves indexed reads.
//                Optional macro FIL_SPAD_ZERO_SKIP_EN adds a per-entry zero flag.
//  Revision    : 1.0  initial release
// ============================================================================
module fil_spad_rx
    import pe_pkg::*;
#(
    parameter int DATA_W = FIL_DATA_W,
    parameter int DEPTH  = FIL_SPAD_DEPTH,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] w_in,
    input  logic [4:0]        p,
    input  logic [4:0]        q,
    input  logic [4:0]        S,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic              rd_err,
    output logic              load_done,
    output logic              cfg_err,
    output logic              rd_zero
);

`ifdef FIL_SPAD_ZERO_SKIP_EN
    localparam int ZBIT = 1;
`else
    localparam int ZBIT = 0;
`endif
    localparam int          MEM_W   = DATA_W + ZBIT;
    localparam logic [14:0] DEPTH_T = 15'(DEPTH);

    fil_rx_state_t     state_q, state_d;
    logic              en_q, en_qq;
    logic              armed_q, armed_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [14:0]       limit_q, limit_d;
    logic              cfg_err_q, cfg_err_d;
    logic              load_done_q, load_done_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_err_q, rd_err_d;
    logic              rd_mask_q, rd_mask_d;

    logic [14:0]       total_now, limit_now;
    logic              cfg_bad_now, start;
    logic              we, re;
    logic [ADDR_W-1:0] waddr;
    logic [MEM_W-1:0]  wdata, rdata;

    // The usable range is min(total, DEPTH); it bounds both writes and reads.
    always_comb begin
        total_now   = 15'(p) * 15'(q) * 15'(S);
        cfg_bad_now = total_now > DEPTH_T;
        limit_now   = cfg_bad_now ? DEPTH_T : total_now;
        start       = armed_q & en_q & ~en_qq & (state_q != LOAD);
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        limit_d     = limit_q;
        cfg_err_d   = cfg_err_q;
        load_done_d = load_done_q;
        armed_d     = armed_q | ~en;
        we          = 1'b0;
        waddr       = wr_ptr_q;

        // Word 0 is already on w_in in the start cycle, so it is written here.
        if (start) begin
            limit_d     = limit_now;
            cfg_err_d   = cfg_bad_now;
            load_done_d = 1'b0;
            wr_ptr_d    = '0;
            if (limit_now == 15'd0) begin
                state_d     = READY;
                load_done_d = 1'b1;
            end else begin
                we       = 1'b1;
                waddr    = '0;
                wr_ptr_d = ADDR_W'(1);
                if (limit_now == 15'd1) begin
                    state_d     = READY;
                    load_done_d = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
        end else if (state_q == LOAD) begin
            if (!en_q) begin
                state_d     = IDLE;
                load_done_d = 1'b0;
            end else begin
                we       = 15'(wr_ptr_q) < limit_q;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (15'(wr_ptr_q) == limit_q - 15'd1) begin
                    state_d     = READY;
                    load_done_d = ~cfg_err_q;
                end
            end
        end
    end

    // Out-of-range reads in READY force rd_data to zero; reads outside READY leave it.
    always_comb begin
        re        = 1'b0;
        rd_vld_d  = 1'b0;
        rd_err_d  = 1'b0;
        rd_mask_d = rd_mask_q;
        if (rd_en) begin
            if ((state_q == READY) && (15'(rd_idx) < limit_q)) begin
                re        = 1'b1;
                rd_vld_d  = 1'b1;
                rd_mask_d = 1'b0;
            end else begin
                rd_err_d = 1'b1;
                if (state_q == READY) begin
                    rd_mask_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            en_qq       <= 1'b0;
            armed_q     <= 1'b0;
            wr_ptr_q    <= '0;
            limit_q     <= '0;
            cfg_err_q   <= 1'b0;
            load_done_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_mask_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            en_q        <= en;
            en_qq       <= en_q;
            armed_q     <= armed_d;
            wr_ptr_q    <= wr_ptr_d;
            limit_q     <= limit_d;
            cfg_err_q   <= cfg_err_d;
            load_done_q <= load_done_d;
            rd_vld_q    <= rd_vld_d;
            rd_err_q    <= rd_err_d;
            rd_mask_q   <= rd_mask_d;
        end
    end

`ifdef FIL_SPAD_ZERO_SKIP_EN
    assign wdata   = {(w_in == '0), w_in};
    assign rd_zero = ~rd_mask_q & rdata[DATA_W];
`else
    assign wdata   = w_in;
    assign rd_zero = 1'b0;
`endif

    fil_spad_mem #(
        .W      (MEM_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (rd_idx),
        .rdata (rdata)
    );

    assign rd_data   = rd_mask_q ? '0 : rdata[DATA_W-1:0];
    assign rd_vld    = rd_vld_q;
    assign rd_err    = rd_err_q;
    assign load_done = load_done_q;
    assign cfg_err   = cfg_err_q;

endmodule : fil_spad_rx
`default_nettype wire
